fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port RES, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port PC, input, 32 bits: the current program counter from the PC register.
REQ-004 The block SHALL have port pcNext, output, 32 bits: the next PC value to the PC register.
REQ-005 The block SHALL have port pcWrite, output, 1 bit: when 1, the PC register loads pcNext at the next edge.
REQ-006 The block SHALL have ports imem_req (output, 1 bit) and imem_addr (output, 32 bits): the instruction-memory request and its address.
REQ-007 The block SHALL have port imem_gnt, input, 1 bit: the memory accepts the request.
REQ-008 The block SHALL have ports imem_rvalid (input, 1 bit) and imem_rdata (input, 32 bits): the memory response.
REQ-009 The block SHALL have ports inst_valid (output, 1 bit), INST (output, 32 bits) and inst_pc (output, 32 bits): the fetched instruction and its address to decode.
REQ-010 The block SHALL have port inst_ready, input, 1 bit: decode accepts the instruction.
REQ-011 The block SHALL have ports redirect_valid (input, 1 bit) and redirect_target (input, 32 bits): a branch/jump redirect.

Function
REQ-012 The block SHALL implement the states IDLE, REQ, WAIT and HOLD.
REQ-013 IDLE SHALL last exactly one cycle after reset release, then go to REQ; pcWrite SHALL be 0 in IDLE.
REQ-014 In REQ the block SHALL drive imem_req=1 and imem_addr=PC, and SHALL hold both stable until imem_gnt=1; on gnt it SHALL go to WAIT.
REQ-015 imem_req SHALL be 0 in every state other than REQ.
REQ-016 In WAIT on imem_rvalid=1 with no pending flush, the block SHALL register INST=imem_rdata and inst_pc=PC, then go to HOLD.
REQ-017 inst_valid SHALL be 1 only in HOLD, and INST and inst_pc SHALL stay stable until the instruction is accepted.
REQ-018 In HOLD with inst_valid&inst_ready and no redirect, the block SHALL drive pcWrite=1 and pcNext=PC+4 combinationally in that cycle, then go to REQ.
REQ-019 PC+4 SHALL be computed modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-020 A redirect SHALL take priority over an accept in the same cycle; the held instruction SHALL be dropped.
REQ-021 Redirect in HOLD: the block SHALL drive pcWrite=1 and pcNext={redirect_target[31:2],2'b00} that cycle, then go to REQ; inst_valid SHALL be 0 the next cycle.
REQ-022 Redirect in IDLE: the block SHALL behave as in HOLD (write the target, go to REQ).
REQ-023 Redirect in REQ or WAIT: the block SHALL latch the aligned target into a pending register and set a flush flag; the outstanding request SHALL still complete (req held until gnt).
REQ-024 On imem_rvalid with the flush flag set, the block SHALL discard imem_rdata, drive pcWrite=1 with pcNext=pending target, clear the flag, and go to REQ.
REQ-025 A newer redirect while the flush flag is set SHALL overwrite the pending target.
REQ-026 pcWrite SHALL be 0 in every case not covered by REQ-018, REQ-021, REQ-022 and REQ-024.
REQ-027 pcNext SHALL be PC+4 whenever pcWrite=0.
REQ-028 Best-case latency SHALL be: REQ with immediate gnt at cycle t, rvalid at t+1, inst_valid at t+2.

Reset
REQ-029 RES=1 SHALL immediately force state=IDLE, the flush flag=0, pending target=0, INST=0, inst_pc=0, inst_valid=0, imem_req=0 and pcWrite=0, regardless of CLK.
REQ-030 Reset mid-transaction SHALL abandon any outstanding request, and imem_rvalid arriving after reset release while in IDLE or REQ SHALL be ignored.

Verification
REQ-031 The bench SHALL cover this scenario: reset, PC=0, gnt and rvalid always 1, rdata=0x00000013, ready=1 -> inst_valid pulses every 3 cycles with inst_pc 0, 4, 8, and pcWrite=1 with pcNext=PC+4 in each HOLD cycle.
REQ-032 The bench SHALL cover this scenario: gnt delayed 3 cycles -> imem_req and imem_addr stay stable for 4 cycles and no pcWrite occurs.
REQ-033 The bench SHALL cover this scenario: in HOLD, redirect_valid=1, target=0x00000103, ready=1 -> pcWrite=1, pcNext=0x00000100, the instruction is not consumed, and the next imem_addr=0x100.
REQ-034 The bench SHALL cover this scenario: redirect target 0x200 in WAIT, rvalid 2 cycles later -> rdata discarded, inst_valid stays 0, pcWrite=1 with pcNext=0x200.
REQ-035 The bench SHALL cover this scenario: PC=0xFFFFFFFC accepted -> pcNext=0x00000000.
REQ-036 The bench SHALL cover this scenario: RES asserted between clock edges while in WAIT -> all outputs are 0 immediately, and after release the block passes through one IDLE cycle then REQ.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-unit bundle: PC register link, instruction-memory request/response,
// decode handoff and branch redirect.
interface fetch_if;
    logic [31:0] PC;
    logic [31:0] pcNext;
    logic        pcWrite;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] INST;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    modport master (
        input  PC, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
               redirect_valid, redirect_target,
        output pcNext, pcWrite, imem_req, imem_addr, inst_valid, INST, inst_pc
    );

    modport slave (
        output PC, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
               redirect_valid, redirect_target,
        input  pcNext, pcWrite, imem_req, imem_addr, inst_valid, INST, inst_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request at PC, hold the returned word
// for decode, then advance PC by 4 or to a redirect target.
module fetch_unit (
    input  logic     CLK,
    input  logic     RES,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic        flush, flush_nxt;
    logic [31:0] pend, pend_nxt;
    logic [31:0] inst_q, inst_pc_q;
    logic        load_inst;
    logic        req;
    logic        pc_write;
    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    logic [31:0] target;

    assign pc_inc = bus.PC + 32'd4;
    assign target = {bus.redirect_target[31:2], 2'b00};

    // NOTE: state registers use non-blocking assignments only; the comb block
    // below assigns every output a default first so no latches are inferred.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state     <= IDLE;
            flush     <= 1'b0;
            pend      <= 32'd0;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
        end else begin
            state <= state_nxt;
            flush <= flush_nxt;
            pend  <= pend_nxt;
            if (load_inst) begin
                inst_q    <= bus.imem_rdata;
                inst_pc_q <= bus.PC;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        flush_nxt = flush;
        pend_nxt  = pend;
        load_inst = 1'b0;
        req       = 1'b0;
        pc_write  = 1'b0;
        pc_next   = pc_inc;
        unique case (state)
            IDLE: begin
                state_nxt = REQ;
                if (bus.redirect_valid) begin
                    pc_write = 1'b1;
                    pc_next  = target;
                end
            end
            REQ: begin
                req = 1'b1;
                if (bus.redirect_valid) begin
                    flush_nxt = 1'b1;
                    pend_nxt  = target;
                end
                if (bus.imem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    flush_nxt = 1'b1;
                    pend_nxt  = target;
                end
                // A redirect arriving together with rvalid is the newest target.
                if (bus.imem_rvalid) begin
                    if (flush || bus.redirect_valid) begin
                        pc_write  = 1'b1;
                        pc_next   = bus.redirect_valid ? target : pend;
                        flush_nxt = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        load_inst = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_write  = 1'b1;
                    pc_next   = target;
                    state_nxt = REQ;
                end else if (bus.inst_ready) begin
                    pc_write  = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset suppresses a PC write even if a redirect is presented meanwhile.
        if (RES) begin
            pc_write = 1'b0;
            pc_next  = pc_inc;
        end
    end

    assign bus.pcWrite    = pc_write;
    assign bus.pcNext     = pc_next;
    assign bus.imem_req   = req;
    assign bus.imem_addr  = req ? bus.PC : 32'd0;
    assign bus.inst_valid = (state == HOLD);
    assign bus.INST       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural PC register in the loop.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic [31:0] pc_reg;
    logic        pc_load;
    logic [31:0] pc_load_val;
    int          n_checks;
    int          n_pass;

    fetch_if bus ();

    fetch_unit dut (.CLK(clk), .RES(rst), .bus(bus));

    assign bus.PC = pc_reg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (pc_load) pc_reg <= pc_load_val;
        else if (bus.pcWrite) pc_reg <= bus.pcNext;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] pc_val);
        rst = 1'b1;
        pc_load = 1'b1;
        pc_load_val = pc_val;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'd0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset;
        rst = 1'b0;
        pc_load = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset(32'h0000_0010);
        #1;
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %0h want 0", bus.imem_req); else n_pass++;
        n_checks++; if (bus.pcWrite !== 1'b0) $display("FAIL rst_pcwrite: got %0h want 0", bus.pcWrite); else n_pass++;
        n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL rst_valid: got %0h want 0", bus.inst_valid); else n_pass++;
        n_checks++; if (bus.INST !== 32'd0) $display("FAIL rst_inst: got %h want 0", bus.INST); else n_pass++;
        n_checks++; if (bus.inst_pc !== 32'd0) $display("FAIL rst_inst_pc: got %h want 0", bus.inst_pc); else n_pass++;
        release_reset();
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL idle_req: got %0h want 0", bus.imem_req); else n_pass++;
        n_checks++; if (bus.pcWrite !== 1'b0) $display("FAIL idle_pcwrite: got %0h want 0", bus.pcWrite); else n_pass++;
        cyc(); #1;
        n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL first_req: got %0h want 1", bus.imem_req); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h10) $display("FAIL first_addr: got %h want 00000010", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_stream;
        do_reset(32'h0);
        bus.imem_gnt = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        bus.inst_ready = 1'b1;
        release_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k))
                $display("FAIL stream_req[%0d]: req=%0h addr=%h want req=1 addr=%h", k, bus.imem_req, bus.imem_addr, 32'(4 * k)); else n_pass++;
            cyc(); #1;
            n_checks++; if (bus.inst_valid !== 1'b0 || bus.pcWrite !== 1'b0)
                $display("FAIL stream_wait[%0d]: valid=%0h pcWrite=%0h want 0/0", k, bus.inst_valid, bus.pcWrite); else n_pass++;
            cyc(); #1;
            n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * k) || bus.INST !== 32'h13)
                $display("FAIL stream_hold[%0d]: valid=%0h pc=%h inst=%h want 1 %h 00000013", k, bus.inst_valid, bus.inst_pc, bus.INST, 32'(4 * k)); else n_pass++;
            n_checks++; if (bus.pcWrite !== 1'b1 || bus.pcNext !== 32'(4 * k + 4))
                $display("FAIL stream_pcnext[%0d]: pcWrite=%0h pcNext=%h want 1 %h", k, bus.pcWrite, bus.pcNext, 32'(4 * k + 4)); else n_pass++;
        end
    endtask

    task automatic test_gnt_delay;
        do_reset(32'h40);
        release_reset();
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) bus.imem_gnt = 1'b1;
            #1;
            n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40 || bus.pcWrite !== 1'b0)
                $display("FAIL gnt_hold[%0d]: req=%0h addr=%h pcWrite=%0h want 1 00000040 0", i, bus.imem_req, bus.imem_addr, bus.pcWrite); else n_pass++;
        end
        cyc(); bus.imem_gnt = 1'b0; #1;
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL gnt_wait_req: got %0h want 0", bus.imem_req); else n_pass++;
        cyc(); bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hCAFE_0001; #1;
        n_checks++; if (bus.pcWrite !== 1'b0 || bus.inst_valid !== 1'b0)
            $display("FAIL gnt_rvalid: pcWrite=%0h valid=%0h want 0/0", bus.pcWrite, bus.inst_valid); else n_pass++;
        cyc(); bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; #1;
        n_checks++; if (bus.inst_valid !== 1'b1 || bus.INST !== 32'hCAFE_0001 || bus.inst_pc !== 32'h40 || bus.pcWrite !== 1'b0)
            $display("FAIL gnt_hold_out: valid=%0h inst=%h pc=%h pcWrite=%0h", bus.inst_valid, bus.INST, bus.inst_pc, bus.pcWrite); else n_pass++;
        cyc(); #1;
        n_checks++; if (bus.inst_valid !== 1'b1 || bus.INST !== 32'hCAFE_0001)
            $display("FAIL gnt_hold_stable: valid=%0h inst=%h want 1 cafe0001", bus.inst_valid, bus.INST); else n_pass++;
        cyc(); bus.inst_ready = 1'b1; #1;
        n_checks++; if (bus.pcWrite !== 1'b1 || bus.pcNext !== 32'h44)
            $display("FAIL gnt_accept: pcWrite=%0h pcNext=%h want 1 00000044", bus.pcWrite, bus.pcNext); else n_pass++;
        cyc(); bus.inst_ready = 1'b0; #1;
        n_checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h44)
            $display("FAIL gnt_next_req: valid=%0h req=%0h addr=%h want 0 1 00000044", bus.inst_valid, bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_hold;
        do_reset(32'h80);
        bus.imem_gnt = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h11;
        release_reset();
        cyc();
        cyc();
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h103;
        bus.inst_ready = 1'b1;
        #1;
        n_checks++; if (bus.inst_valid !== 1'b1 || bus.pcWrite !== 1'b1 || bus.pcNext !== 32'h100)
            $display("FAIL redir_hold: valid=%0h pcWrite=%0h pcNext=%h want 1 1 00000100", bus.inst_valid, bus.pcWrite, bus.pcNext); else n_pass++;
        cyc(); bus.redirect_valid = 1'b0; bus.inst_ready = 1'b0; bus.imem_gnt = 1'b0; #1;
        n_checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100)
            $display("FAIL redir_hold_next: valid=%0h req=%0h addr=%h want 0 1 00000100", bus.inst_valid, bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_wait;
        do_reset(32'h10);
        bus.imem_gnt = 1'b1;
        bus.inst_ready = 1'b1;
        release_reset();
        cyc(); bus.redirect_valid = 1'b1; bus.redirect_target = 32'h300; #1;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.pcWrite !== 1'b0)
            $display("FAIL redir_req: req=%0h addr=%h pcWrite=%0h want 1 00000010 0", bus.imem_req, bus.imem_addr, bus.pcWrite); else n_pass++;
        cyc(); bus.redirect_target = 32'h202; #1;
        n_checks++; if (bus.imem_req !== 1'b0 || bus.pcWrite !== 1'b0)
            $display("FAIL redir_wait: req=%0h pcWrite=%0h want 0 0", bus.imem_req, bus.pcWrite); else n_pass++;
        cyc(); bus.redirect_valid = 1'b0; #1;
        n_checks++; if (bus.inst_valid !== 1'b0 || bus.pcWrite !== 1'b0)
            $display("FAIL redir_wait2: valid=%0h pcWrite=%0h want 0 0", bus.inst_valid, bus.pcWrite); else n_pass++;
        cyc(); bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; #1;
        n_checks++; if (bus.pcWrite !== 1'b1 || bus.pcNext !== 32'h200 || bus.inst_valid !== 1'b0)
            $display("FAIL redir_flush: pcWrite=%0h pcNext=%h valid=%0h want 1 00000200 0", bus.pcWrite, bus.pcNext, bus.inst_valid); else n_pass++;
        cyc(); bus.imem_rvalid = 1'b0; #1;
        n_checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200)
            $display("FAIL redir_flush_next: valid=%0h req=%0h addr=%h want 0 1 00000200", bus.inst_valid, bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_wrap;
        do_reset(32'hFFFF_FFFC);
        bus.imem_gnt = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h13;
        bus.inst_ready = 1'b1;
        release_reset();
        cyc(); #1;
        n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", bus.imem_addr); else n_pass++;
        cyc();
        cyc(); #1;
        n_checks++; if (bus.inst_pc !== 32'hFFFF_FFFC || bus.pcWrite !== 1'b1 || bus.pcNext !== 32'h0)
            $display("FAIL wrap_pcnext: pc=%h pcWrite=%0h pcNext=%h want fffffffc 1 00000000", bus.inst_pc, bus.pcWrite, bus.pcNext); else n_pass++;
        cyc(); #1;
        n_checks++; if (bus.imem_addr !== 32'h0) $display("FAIL wrap_next_addr: got %h want 00000000", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_reset_wait;
        do_reset(32'h20);
        bus.imem_gnt = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h55;
        release_reset();
        cyc();
        cyc();
        cyc(); bus.inst_ready = 1'b1; #1;
        n_checks++; if (bus.inst_valid !== 1'b1 || bus.INST !== 32'h55)
            $display("FAIL rw_hold: valid=%0h inst=%h want 1 00000055", bus.inst_valid, bus.INST); else n_pass++;
        cyc(); bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b0;
        cyc(); #1;
        n_checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.INST !== 32'h55)
            $display("FAIL rw_wait: req=%0h valid=%0h inst=%h want 0 0 00000055", bus.imem_req, bus.inst_valid, bus.INST); else n_pass++;
        #1;
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h400;
        #1;
        n_checks++; if (bus.imem_req !== 1'b0 || bus.pcWrite !== 1'b0 || bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h0)
            $display("FAIL rw_async_ctl: req=%0h pcWrite=%0h valid=%0h addr=%h want all 0", bus.imem_req, bus.pcWrite, bus.inst_valid, bus.imem_addr); else n_pass++;
        n_checks++; if (bus.INST !== 32'h0 || bus.inst_pc !== 32'h0)
            $display("FAIL rw_async_data: inst=%h inst_pc=%h want 0 0", bus.INST, bus.inst_pc); else n_pass++;
        bus.redirect_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h77;
        #1;
        n_checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.pcWrite !== 1'b0)
            $display("FAIL rw_idle: req=%0h valid=%0h pcWrite=%0h want 0 0 0", bus.imem_req, bus.inst_valid, bus.pcWrite); else n_pass++;
        cyc(); #1;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24)
            $display("FAIL rw_req: req=%0h addr=%h want 1 00000024", bus.imem_req, bus.imem_addr); else n_pass++;
        cyc(); #1;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.inst_valid !== 1'b0 || bus.INST !== 32'h0)
            $display("FAIL rw_ignore_rvalid: req=%0h valid=%0h inst=%h want 1 0 00000000", bus.imem_req, bus.inst_valid, bus.INST); else n_pass++;
        bus.imem_rvalid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst = 1'b1;
        pc_load = 1'b0;
        pc_load_val = 32'd0;
        test_reset();
        test_stream();
        test_gnt_delay();
        test_redirect_hold();
        test_redirect_wait();
        test_wrap();
        test_reset_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
